// File: rtl/rns_pkg.sv
// Shared constants for the RNS input datapath: FSM encodings, widths and
// default/minimum moduli.
package rns_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned RES_W  = 3;
  localparam int unsigned NUM_CH = 3;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic [RES_W-1:0] M0_DEF  = 3'd7;
  localparam logic [RES_W-1:0] M1_DEF  = 3'd5;
  localparam logic [RES_W-1:0] M2_DEF  = 3'd3;
  localparam logic [RES_W-1:0] MOD_MIN = 3'd2;

endpackage

// File: rtl/modulus_6_3_BIT.sv
// Combinational 6-bit dividend mod 3-bit modulus, restoring shift-subtract.
// Exact for moduli 2..7; a zero modulus yields a defined but meaningless value.
module modulus_6_3_BIT (
  input  logic [5:0] dividend,
  input  logic [2:0] moduli,
  output logic [2:0] remainder
);

  logic [3:0] rem;

  always_comb begin
    rem = 4'd0;
    for (int i = 5; i >= 0; i--) begin
      rem = {rem[2:0], dividend[i]};
      if (rem >= {1'b0, moduli}) rem = rem - {1'b0, moduli};
    end
    remainder = rem[2:0];
  end

endmodule

// File: rtl/rns_forward_sequencer.sv
// Sequential binary-to-RNS forward converter: one operand in, three residues
// out, one shared modulus unit stepped across the channels one per cycle.
module rns_forward_sequencer
  import rns_pkg::*;
#(
  parameter logic [RES_W-1:0] M0_RST = M0_DEF,
  parameter logic [RES_W-1:0] M1_RST = M1_DEF,
  parameter logic [RES_W-1:0] M2_RST = M2_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_res0,
  output logic [RES_W-1:0] out_res1,
  output logic [RES_W-1:0] out_res2,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_idx,
  input  logic [RES_W-1:0] cfg_modulus,
  output logic             cfg_err,
  output logic             busy
);

  state_t             state_q, state_d;
  logic [1:0]         idx_q;
  logic [OP_W-1:0]    operand_q;
  logic [RES_W-1:0]   res_q [NUM_CH];
  logic [RES_W-1:0]   mod_q [NUM_CH];
  logic               cfg_err_q;
  logic               busy_q;

  logic               accept;
  logic               cfg_ok;
  logic [RES_W-1:0]   cur_mod;
  logic [RES_W-1:0]   cur_res;

  always_comb begin
    in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    accept   = in_valid & in_ready;
    cfg_ok   = (state_q == IDLE) & (cfg_idx <= 2'd2) & (cfg_modulus >= MOD_MIN);
  end

  always_comb begin
    case (idx_q)
      2'd1:    cur_mod = mod_q[1];
      2'd2:    cur_mod = mod_q[2];
      default: cur_mod = mod_q[0];
    endcase
  end

  modulus_6_3_BIT u_mod (
    .dividend  (operand_q),
    .moduli    (cur_mod),
    .remainder (cur_res)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (idx_q == 2'd2) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      operand_q <= '0;
      cfg_err_q <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) res_q[i] <= '0;
      mod_q[0]  <= M0_RST;
      mod_q[1]  <= M1_RST;
      mod_q[2]  <= M2_RST;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != IDLE);
      cfg_err_q <= cfg_we & ~cfg_ok;
      if (accept) begin
        operand_q <= in_data;
        idx_q     <= 2'd0;
      end else if (state_q == CALC) begin
        idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end
      if (state_q == CALC) begin
        case (idx_q)
          2'd1:    res_q[1] <= cur_res;
          2'd2:    res_q[2] <= cur_res;
          default: res_q[0] <= cur_res;
        endcase
      end
      // Same-cycle write and accept both land; CALC starts next cycle on the new value.
      if (cfg_we && cfg_ok) begin
        case (cfg_idx)
          2'd1:    mod_q[1] <= cfg_modulus;
          2'd2:    mod_q[2] <= cfg_modulus;
          default: mod_q[0] <= cfg_modulus;
        endcase
      end
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_res0  = res_q[0];
  assign out_res1  = res_q[1];
  assign out_res2  = res_q[2];
  assign cfg_err   = cfg_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rns_forward_sequencer.sv
// Directed bench for rns_forward_sequencer with hand-computed residue triples.
module tb_rns_forward_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [5:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_res0, out_res1, out_res2;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [2:0] cfg_modulus;
  logic       cfg_err;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rns_forward_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_res0    (out_res0),
    .out_res1    (out_res1),
    .out_res2    (out_res2),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_modulus (cfg_modulus),
    .cfg_err     (cfg_err),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick3();
    tick();
    tick();
    tick();
  endtask

  task automatic check_triple(input string tag, input logic [2:0] e0, input logic [2:0] e1,
                              input logic [2:0] e2);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".res0"}, 32'(out_res0), 32'(e0));
    check({tag, ".res1"}, 32'(out_res1), 32'(e1));
    check({tag, ".res2"}, 32'(out_res2), 32'(e2));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".res"}, {23'd0, out_res0, out_res1, out_res2}, 32'd0);
    check({tag, ".cfg_err"}, 32'(cfg_err), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_modulus = '0;
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Single conversion of 63 against 7/5/3
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 6'd63;
    check("t1.in_ready_idle", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t1.busy", 32'(busy), 32'd1);
    check("t1.in_ready_calc", 32'(in_ready), 32'd0);
    tick();
    tick();
    check("t1.valid_early", 32'(out_valid), 32'd0);
    tick();
    check_triple("t1", 3'd0, 3'd3, 3'd0);
    tick();
    check("t1.valid_after", 32'(out_valid), 32'd0);
    check("t1.in_ready_after", 32'(in_ready), 32'd1);
    check("t1.busy_after", 32'(busy), 32'd0);

    // Backpressure: 50 held for 10 cycles
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 6'd50;
    tick();
    in_valid = 1'b0;
    tick3();
    for (int i = 0; i < 10; i++) begin
      check_triple("t2.hold", 3'd1, 3'd0, 3'd2);
      check("t2.in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("t2.in_ready_release", 32'(in_ready), 32'd1);
    tick();
    check("t2.released", 32'(out_valid), 32'd0);

    // Back-to-back 50, 63, 0
    in_valid = 1'b1;
    in_data = 6'd50;
    tick();
    in_data = 6'd63;
    tick3();
    check_triple("t3.a", 3'd1, 3'd0, 3'd2);
    check("t3.a_ready", 32'(in_ready), 32'd1);
    tick();
    in_data = 6'd0;
    check("t3.no_gap", 32'(busy), 32'd1);
    tick3();
    check_triple("t3.b", 3'd0, 3'd3, 3'd0);
    tick();
    in_valid = 1'b0;
    tick3();
    check_triple("t3.c", 3'd0, 3'd0, 3'd0);
    tick();
    check("t3.idle_valid", 32'(out_valid), 32'd0);
    check("t3.idle_busy", 32'(busy), 32'd0);

    // Same-cycle write idx0=4 and accept 45
    cfg_we = 1'b1;
    cfg_idx = 2'd0;
    cfg_modulus = 3'd4;
    in_valid = 1'b1;
    in_data = 6'd45;
    tick();
    cfg_we = 1'b0;
    in_valid = 1'b0;
    check("t4.no_err", 32'(cfg_err), 32'd0);
    tick3();
    check_triple("t4", 3'd1, 3'd0, 3'd0);
    tick();
    cfg_we = 1'b1;
    cfg_idx = 2'd3;
    cfg_modulus = 3'd6;
    tick();
    cfg_we = 1'b0;
    check("t4.err_idx3", 32'(cfg_err), 32'd1);
    tick();
    check("t4.err_once", 32'(cfg_err), 32'd0);

    // Illegal modulus 1 in IDLE, then a legal-looking write during CALC
    cfg_we = 1'b1;
    cfg_idx = 2'd1;
    cfg_modulus = 3'd1;
    tick();
    cfg_we = 1'b0;
    check("t5.err_mod1", 32'(cfg_err), 32'd1);
    tick();
    check("t5.err_mod1_once", 32'(cfg_err), 32'd0);
    in_valid = 1'b1;
    in_data = 6'd50;
    tick();
    in_valid = 1'b0;
    cfg_we = 1'b1;
    cfg_idx = 2'd2;
    cfg_modulus = 3'd7;
    tick();
    cfg_we = 1'b0;
    check("t5.err_calc", 32'(cfg_err), 32'd1);
    tick();
    check("t5.err_calc_once", 32'(cfg_err), 32'd0);
    tick();
    check_triple("t5", 3'd2, 3'd0, 3'd2);
    tick();

    // Reset two cycles after accept
    in_valid = 1'b1;
    in_data = 6'd63;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("t6.rst");
    tick();
    rst = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data = 6'd10;
    tick();
    in_valid = 1'b0;
    tick3();
    check_triple("t6.after", 3'd3, 3'd0, 3'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
